spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning idle cycles a locked grant may sit without a new access (8-bit, 1..255).
REQ-002 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports cmd0/wr0/rd0  input  1 each  requester 0 access strobes (at most one high), held until ack0.
REQ-005 SHALL have ports lock0  input  1  keep grant after current access; din0  input  11  requester 0 write data/settings.
REQ-006 SHALL have ports dout0  output  9  read data to requester 0; ack0  output  1  one-cycle completion pulse; gnt0  output  1  requester 0 owns SPI.
REQ-007 SHALL have ports cmd1/wr1/rd1, lock1, din1, dout1, ack1, gnt1 identical in direction, width and meaning for requester 1.
REQ-008 SHALL have ports spi_cmd/spi_wr/spi_rd  output  1 each, spi_din  output  11  forwarded access to SPI core.
REQ-009 SHALL have ports spi_dout  input  9, spi_ack  input  1  SPI core read data and completion.
REQ-010 SHALL have ports err0, err1  output  1  one-cycle lock-timeout pulse per requester.

Function
REQ-011 SHALL implement FSM IDLE, ISSUE, LOCKED; owner register own (0/1) and round-robin pointer last.
REQ-012 IDLE: SHALL grant on any strobe; single requester wins; both pending -> requester != last wins; go ISSUE next cycle.
REQ-013 On entering ISSUE SHALL register winner's din and strobe into spi_din/spi_cmd/spi_wr/spi_rd (1-cycle latency from request to SPI strobe) and assert gntN.
REQ-014 ISSUE: SHALL hold spi strobe and spi_din stable until spi_ack; requester din/strobe changes SHALL be ignored meanwhile.
REQ-015 On spi_ack SHALL drop spi strobe next cycle, capture spi_dout into doutN, pulse ackN one cycle (registered, 1 cycle after spi_ack), set last=own.
REQ-016 After completion: lockN high (sampled with spi_ack) -> LOCKED with grant kept; else -> IDLE, gntN low.
REQ-017 Requester SHALL drop strobe in the cycle ackN is high; arbiter SHALL not accept a new strobe from owner in that same cycle.
REQ-018 LOCKED: owner strobe -> ISSUE (same path as REQ-013); owner lock low and no strobe -> IDLE; other requester's strobes SHALL wait.
REQ-019 doutN SHALL hold last captured value until next read completion for that requester; non-owner dout SHALL not change.
REQ-020 gnt0 and gnt1 SHALL never be high simultaneously; spi strobes SHALL be at most one-hot.
REQ-021 spi_ack in IDLE or LOCKED SHALL be ignored.

Reset
REQ-022 On rst: state IDLE, own=0, last=1 (requester 0 wins first tie), all strobes, gnt, ack, err low, spi_din/dout0/dout1 zero.
REQ-023 rst mid-ISSUE SHALL abort immediately: spi strobes low next edge, no ackN issued for aborted access.

Configuration
REQ-024 Macro SPI_ARBITER_TIMEOUT_EN defined: 8-bit counter clears on entering LOCKED and on each owner strobe, increments in LOCKED; reaching TIMEOUT -> IDLE, grant dropped, errN pulse one cycle.
REQ-025 Macro undefined: no counter, LOCKED held indefinitely while lockN high, err0/err1 tied 0.

Verification
REQ-026 Single write: wr0=1, din0=0x155, spi_ack after 4 cycles -> spi_wr high 1 cycle after wr0 with spi_din=0x155, ack0 pulse 1 cycle after spi_ack, gnt0 falls.
REQ-027 Tie: rd0 and rd1 same cycle after reset -> requester 0 served first, then requester 1 without idle-gap beyond 1 cycle; next tie -> requester 1 first.
REQ-028 Lock: lock1=1, three wr1 accesses while rd0 pending -> all three served before rd0; gnt0 never high meanwhile.
REQ-029 Read data: rd0, spi_dout=0x1A5 at spi_ack -> dout0=0x1A5 with ack0, dout1 unchanged.
REQ-030 Timeout (macro defined, TIMEOUT=8): lock0 held, no strobe -> err0 pulse 8 cycles after entering LOCKED, gnt0 low; macro undefined -> gnt0 stays high, err0 0.
REQ-031 rst asserted 2 cycles into ISSUE -> spi strobes low after next edge, no ack0, next access proceeds normally.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI core between two requesters.
// Round-robin on ties, optional lock so an owner can run back-to-back accesses.
// Define SPI_ARBITER_TIMEOUT_EN to add a lock-timeout counter (err0/err1 pulses);
// without it a locked grant is held for as long as the owner keeps lockN high.
module spi_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd0,
  input  logic        wr0,
  input  logic        rd0,
  input  logic        lock0,
  input  logic [10:0] din0,
  output logic [8:0]  dout0,
  output logic        ack0,
  output logic        gnt0,
  input  logic        cmd1,
  input  logic        wr1,
  input  logic        rd1,
  input  logic        lock1,
  input  logic [10:0] din1,
  output logic [8:0]  dout1,
  output logic        ack1,
  output logic        gnt1,
  output logic        spi_cmd,
  output logic        spi_wr,
  output logic        spi_rd,
  output logic [10:0] spi_din,
  input  logic [8:0]  spi_dout,
  input  logic        spi_ack,
  output logic        err0,
  output logic        err1
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        own_r, own_s;
  logic        last_r, last_s;
  logic        spi_cmd_r, spi_cmd_s;
  logic        spi_wr_r, spi_wr_s;
  logic        spi_rd_r, spi_rd_s;
  logic [10:0] spi_din_r, spi_din_s;
  logic        gnt0_r, gnt0_s;
  logic        gnt1_r, gnt1_s;
  logic        ack0_r, ack0_s;
  logic        ack1_r, ack1_s;
  logic [8:0]  dout0_r, dout0_s;
  logic [8:0]  dout1_r, dout1_s;

  logic        req0_s, req1_s;
  logic        owner_req_s, owner_lock_s;
  logic        load_s, win_s;

`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  cnt_r, cnt_s;
  logic        err0_r, err0_s;
  logic        err1_r, err1_s;
`endif

  // A requester whose ack is showing is ignored for that cycle: its strobe is
  // still the one that was just completed.
  assign req0_s       = (cmd0 | wr0 | rd0) & ~ack0_r;
  assign req1_s       = (cmd1 | wr1 | rd1) & ~ack1_r;
  assign owner_req_s  = own_r ? req1_s : req0_s;
  assign owner_lock_s = own_r ? lock1 : lock0;

  // Next-state and next-register values for the arbitration FSM.
  always_comb begin
    state_s   = state_r;
    own_s     = own_r;
    last_s    = last_r;
    spi_cmd_s = spi_cmd_r;
    spi_wr_s  = spi_wr_r;
    spi_rd_s  = spi_rd_r;
    spi_din_s = spi_din_r;
    gnt0_s    = gnt0_r;
    gnt1_s    = gnt1_r;
    ack0_s    = 1'b0;
    ack1_s    = 1'b0;
    dout0_s   = dout0_r;
    dout1_s   = dout1_r;
    load_s    = 1'b0;
    win_s     = 1'b0;
`ifdef SPI_ARBITER_TIMEOUT_EN
    cnt_s     = cnt_r;
    err0_s    = 1'b0;
    err1_s    = 1'b0;
`endif

    case (state_r)
      ST_IDLE: begin
        if (req0_s && req1_s) begin
          load_s = 1'b1;
          win_s  = ~last_r;
        end else if (req0_s) begin
          load_s = 1'b1;
          win_s  = 1'b0;
        end else if (req1_s) begin
          load_s = 1'b1;
          win_s  = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end

      ST_ISSUE: begin
        if (spi_ack) begin
          spi_cmd_s = 1'b0;
          spi_wr_s  = 1'b0;
          spi_rd_s  = 1'b0;
          ack0_s    = ~own_r;
          ack1_s    = own_r;
          last_s    = own_r;
          // Only a read brings back data; writes and commands leave dout alone.
          if (spi_rd_r) begin
            if (own_r) begin
              dout1_s = spi_dout;
            end else begin
              dout0_s = spi_dout;
            end
          end else begin
            dout0_s = dout0_r;
          end
          if (owner_lock_s) begin
            state_s = ST_LOCKED;
`ifdef SPI_ARBITER_TIMEOUT_EN
            cnt_s   = 8'd0;
`endif
          end else begin
            state_s = ST_IDLE;
            gnt0_s  = 1'b0;
            gnt1_s  = 1'b0;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end

      ST_LOCKED: begin
        if (owner_req_s) begin
          load_s = 1'b1;
          win_s  = own_r;
        end else if (!owner_lock_s) begin
          state_s = ST_IDLE;
          gnt0_s  = 1'b0;
          gnt1_s  = 1'b0;
        end else begin
`ifdef SPI_ARBITER_TIMEOUT_EN
          if (cnt_r == TIMEOUT_LAST) begin
            state_s = ST_IDLE;
            gnt0_s  = 1'b0;
            gnt1_s  = 1'b0;
            err0_s  = ~own_r;
            err1_s  = own_r;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
`else
          state_s = ST_LOCKED;
`endif
        end
      end

      default: begin
        state_s   = ST_IDLE;
        spi_cmd_s = 1'b0;
        spi_wr_s  = 1'b0;
        spi_rd_s  = 1'b0;
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
      end
    endcase

    // Start of a new access: latch the winner's strobe and data toward the core.
    if (load_s) begin
      state_s   = ST_ISSUE;
      own_s     = win_s;
      spi_cmd_s = win_s ? cmd1 : cmd0;
      spi_wr_s  = win_s ? wr1 : wr0;
      spi_rd_s  = win_s ? rd1 : rd0;
      spi_din_s = win_s ? din1 : din0;
      gnt0_s    = ~win_s;
      gnt1_s    = win_s;
`ifdef SPI_ARBITER_TIMEOUT_EN
      cnt_s     = 8'd0;
`endif
    end else begin
      own_s = own_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Owner, round-robin pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_r     <= 1'b0;
      last_r    <= 1'b1;
      spi_cmd_r <= 1'b0;
      spi_wr_r  <= 1'b0;
      spi_rd_r  <= 1'b0;
      spi_din_r <= 11'd0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      ack0_r    <= 1'b0;
      ack1_r    <= 1'b0;
      dout0_r   <= 9'd0;
      dout1_r   <= 9'd0;
    end else begin
      own_r     <= own_s;
      last_r    <= last_s;
      spi_cmd_r <= spi_cmd_s;
      spi_wr_r  <= spi_wr_s;
      spi_rd_r  <= spi_rd_s;
      spi_din_r <= spi_din_s;
      gnt0_r    <= gnt0_s;
      gnt1_r    <= gnt1_s;
      ack0_r    <= ack0_s;
      ack1_r    <= ack1_s;
      dout0_r   <= dout0_s;
      dout1_r   <= dout1_s;
    end
  end

`ifdef SPI_ARBITER_TIMEOUT_EN
  // Lock-timeout counter and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= 8'd0;
      err0_r <= 1'b0;
      err1_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      err0_r <= err0_s;
      err1_r <= err1_s;
    end
  end

  assign err0 = err0_r;
  assign err1 = err1_r;
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  assign spi_cmd = spi_cmd_r;
  assign spi_wr  = spi_wr_r;
  assign spi_rd  = spi_rd_r;
  assign spi_din = spi_din_r;
  assign gnt0    = gnt0_r;
  assign gnt1    = gnt1_r;
  assign ack0    = ack0_r;
  assign ack1    = ack1_r;
  assign dout0   = dout0_r;
  assign dout1   = dout1_r;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed testbench for spi_arbiter. Inputs change on the falling edge,
// outputs are checked on the falling edge (half a cycle after the DUT edge).
// Expectations follow SPI_ARBITER_TIMEOUT_EN when the timeout scenario differs.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd0 = 1'b0, wr0 = 1'b0, rd0 = 1'b0, lock0 = 1'b0;
  logic [10:0] din0 = 11'd0;
  logic [8:0]  dout0;
  logic        ack0, gnt0;
  logic        cmd1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0, lock1 = 1'b0;
  logic [10:0] din1 = 11'd0;
  logic [8:0]  dout1;
  logic        ack1, gnt1;
  logic        spi_cmd, spi_wr, spi_rd;
  logic [10:0] spi_din;
  logic [8:0]  spi_dout = 9'd0;
  logic        spi_ack = 1'b0;
  logic        err0, err1;

  int checks = 0;
  int fails  = 0;

  spi_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd0(cmd0), .wr0(wr0), .rd0(rd0), .lock0(lock0), .din0(din0),
    .dout0(dout0), .ack0(ack0), .gnt0(gnt0),
    .cmd1(cmd1), .wr1(wr1), .rd1(rd1), .lock1(lock1), .din1(din1),
    .dout1(dout1), .ack1(ack1), .gnt1(gnt1),
    .spi_cmd(spi_cmd), .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_din(spi_din),
    .spi_dout(spi_dout), .spi_ack(spi_ack),
    .err0(err0), .err1(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // SPI core completes the access currently on the bus with read data d.
  task automatic serve(input logic [8:0] d);
    spi_dout = d;
    spi_ack  = 1'b1;
    tick();
    spi_ack  = 1'b0;
    spi_dout = 9'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_strobes", {spi_cmd, spi_wr, spi_rd}, 3'b000);
    chk("rst_acks", {ack0, ack1, err0, err1}, 4'b0000);
    chk("rst_spi_din", spi_din, 11'h000);
    chk("rst_douts", {dout0, dout1}, 18'h0);
    rst = 1'b0;

    // Single write: strobe reaches the core one cycle later, din changes ignored
    wr0 = 1'b1; din0 = 11'h155;
    tick();
    chk("wr_spi_wr", spi_wr, 1'b1);
    chk("wr_spi_din", spi_din, 11'h155);
    chk("wr_gnt0", gnt0, 1'b1);
    chk("wr_gnt1", gnt1, 1'b0);
    chk("wr_other_strobes", {spi_cmd, spi_rd}, 2'b00);
    din0 = 11'h0AA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_hold_wr", spi_wr, 1'b1);
      chk("wr_hold_din", spi_din, 11'h155);
    end
    serve(9'h07F);
    chk("wr_ack0", ack0, 1'b1);
    chk("wr_strobe_drop", spi_wr, 1'b0);
    chk("wr_gnt0_fall", gnt0, 1'b0);
    chk("wr_no_dout", dout0, 9'h000);
    wr0 = 1'b0;
    tick();
    chk("wr_ack0_pulse", ack0, 1'b0);

    // Read data lands in dout0 with ack0, dout1 untouched
    rd0 = 1'b1;
    tick();
    chk("rd_spi_rd", spi_rd, 1'b1);
    serve(9'h1A5);
    chk("rd_ack0", ack0, 1'b1);
    chk("rd_dout0", dout0, 9'h1A5);
    chk("rd_dout1", dout1, 9'h000);
    chk("rd_ack1", ack1, 1'b0);
    rd0 = 1'b0;
    tick();

    // spi_ack while idle is ignored
    spi_dout = 9'h0FF; spi_ack = 1'b1;
    tick();
    spi_ack = 1'b0; spi_dout = 9'd0;
    chk("idle_ack_ignored", {ack0, ack1}, 2'b00);
    chk("idle_dout_hold", dout0, 9'h1A5);

    // Reset again so the tie starts from the reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_dout0", dout0, 9'h000);

    // First tie after reset: requester 0 wins, requester 1 follows after one cycle
    rd0 = 1'b1; rd1 = 1'b1; din0 = 11'h011; din1 = 11'h022;
    tick();
    chk("tie1_gnt", {gnt0, gnt1}, 2'b10);
    chk("tie1_din", spi_din, 11'h011);
    serve(9'h0A0);
    chk("tie1_ack0", ack0, 1'b1);
    chk("tie1_dout0", dout0, 9'h0A0);
    chk("tie1_gnt_gap", {gnt0, gnt1, spi_rd}, 3'b000);
    rd0 = 1'b0;
    tick();
    chk("tie1_second_gnt", {gnt0, gnt1}, 2'b01);
    chk("tie1_second_rd", spi_rd, 1'b1);
    chk("tie1_second_din", spi_din, 11'h022);
    serve(9'h0B1);
    chk("tie1_ack1", ack1, 1'b1);
    chk("tie1_dout1", dout1, 9'h0B1);
    chk("tie1_dout0_hold", dout0, 9'h0A0);
    rd1 = 1'b0;
    tick();

    // Lone access by requester 0 makes it the most recent owner
    rd0 = 1'b1; din0 = 11'h033;
    tick();
    chk("solo_gnt0", gnt0, 1'b1);
    serve(9'h0C2);
    chk("solo_dout0", dout0, 9'h0C2);
    rd0 = 1'b0;
    tick();

    // Next tie: requester 0 was served last, so requester 1 goes first
    rd0 = 1'b1; rd1 = 1'b1; din0 = 11'h044; din1 = 11'h055;
    tick();
    chk("tie2_gnt", {gnt0, gnt1}, 2'b01);
    chk("tie2_din", spi_din, 11'h055);
    serve(9'h0D3);
    chk("tie2_ack1", ack1, 1'b1);
    chk("tie2_dout1", dout1, 9'h0D3);
    chk("tie2_dout0_hold", dout0, 9'h0C2);
    rd1 = 1'b0;
    tick();
    chk("tie2_second_gnt", {gnt0, gnt1}, 2'b10);
    chk("tie2_second_din", spi_din, 11'h044);
    serve(9'h0E4);
    chk("tie2_dout0", dout0, 9'h0E4);
    rd0 = 1'b0;
    tick();

    // Lock: three writes by requester 1 complete before the pending rd0
    wr1 = 1'b1; lock1 = 1'b1; din1 = 11'h101;
    tick();
    chk("lk_a_gnt1", gnt1, 1'b1);
    chk("lk_a_din", spi_din, 11'h101);
    rd0 = 1'b1;
    serve(9'h000);
    chk("lk_a_ack1", ack1, 1'b1);
    chk("lk_a_gnt_kept", {gnt0, gnt1}, 2'b01);
    wr1 = 1'b0;
    tick();
    chk("lk_hold_gnt", {gnt0, gnt1}, 2'b01);
    chk("lk_hold_strobes", {spi_cmd, spi_wr, spi_rd}, 3'b000);
    wr1 = 1'b1; din1 = 11'h102;
    tick();
    chk("lk_b_wr", spi_wr, 1'b1);
    chk("lk_b_din", spi_din, 11'h102);
    chk("lk_b_gnt0", gnt0, 1'b0);
    serve(9'h000);
    chk("lk_b_ack1", ack1, 1'b1);
    wr1 = 1'b0;
    tick();
    chk("lk_b_gnt", {gnt0, gnt1}, 2'b01);
    wr1 = 1'b1; din1 = 11'h103; lock1 = 1'b0;
    tick();
    chk("lk_c_din", spi_din, 11'h103);
    chk("lk_c_gnt0", gnt0, 1'b0);
    serve(9'h000);
    chk("lk_c_ack1", ack1, 1'b1);
    chk("lk_c_release", {gnt0, gnt1}, 2'b00);
    wr1 = 1'b0;
    tick();
    chk("lk_rd0_gnt", {gnt0, gnt1}, 2'b10);
    chk("lk_rd0_strobe", spi_rd, 1'b1);
    serve(9'h0F5);
    chk("lk_rd0_dout", dout0, 9'h0F5);
    rd0 = 1'b0;
    tick();

    // Lock timeout: lock0 held with no further access after one write
    wr0 = 1'b1; lock0 = 1'b1; din0 = 11'h1AB;
    tick();
    chk("to_gnt0", gnt0, 1'b1);
    serve(9'h000);
    chk("to_ack0", ack0, 1'b1);
    wr0 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("to_wait_err0", err0, 1'b0);
      chk("to_wait_gnt0", gnt0, 1'b1);
    end
    tick();
`ifdef SPI_ARBITER_TIMEOUT_EN
    chk("to_err0", err0, 1'b1);
    chk("to_gnt0_drop", gnt0, 1'b0);
`else
    chk("to_err0", err0, 1'b0);
    chk("to_gnt0_kept", gnt0, 1'b1);
`endif
    chk("to_err1", err1, 1'b0);
    tick();
    chk("to_err0_pulse", err0, 1'b0);
    lock0 = 1'b0;
    tick();
    chk("to_unlock_gnt0", gnt0, 1'b0);

    // Reset two cycles into an access aborts it without an ack
    wr0 = 1'b1; din0 = 11'h1F0;
    tick();
    chk("ab_wr", spi_wr, 1'b1);
    tick();
    chk("ab_wr_hold", spi_wr, 1'b1);
    rst = 1'b1;
    tick();
    chk("ab_strobes", {spi_cmd, spi_wr, spi_rd}, 3'b000);
    chk("ab_gnt_ack", {gnt0, ack0}, 2'b00);
    chk("ab_spi_din", spi_din, 11'h000);
    rst = 1'b0;
    tick();
    chk("ab_retry_wr", spi_wr, 1'b1);
    chk("ab_retry_din", spi_din, 11'h1F0);
    chk("ab_retry_gnt_ack", {gnt0, ack0}, 2'b10);
    serve(9'h000);
    chk("ab_retry_ack0", ack0, 1'b1);
    chk("ab_retry_gnt0", gnt0, 1'b0);
    wr0 = 1'b0;
    tick();
    chk("ab_retry_ack_pulse", ack0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
